clk_div_monitor: RTL and testbench
==================================

// Module: clk_div_monitor
// PURPOSE
//  Receiving end of a clock-divider output: samples a divided clock (e.g. divide-by-3, 50% duty)
//  in the source clock domain and measures its period and high time in source-clock cycles.
//  Declares lock after LOCK_CNT consecutive correct periods and flags/counts faults thereafter.
//  Sits beside each clock divider as a built-in checker; status feeds CSR/debug logic.
// PARAMETERS
//  DIV          3   expected division ratio (>=2); period must equal DIV clk cycles
//  LOCK_CNT     4   consecutive good periods required to assert locked (>=1)
//  SYNC_STAGES  2   flops in the div_clk sampling chain (>=1)
//  CW           8   width of period/high_cnt counters; must hold 2*DIV+1
// PORTS
//  clk       in   1   source clock (same clock that drives the divider)
//  rstn      in   1   asynchronous active-low reset
//  en        in   1   monitor enable; low forces IDLE
//  div_clk   in   1   divided clock under test
//  clr_err   in   1   single-cycle pulse: leave FAULT, clear err_cnt
//  locked    out  1   ratio and duty verified, state LOCKED
//  err       out  1   one-cycle pulse per detected fault
//  err_cnt   out  8   saturating fault count (stops at 255)
//  period    out  CW  last measured rise-to-rise interval, clk cycles
//  high_cnt  out  CW  clk cycles div_clk sampled high within that interval
// BEHAVIOUR
//  Reset: all flops cleared; locked=0, err=0, err_cnt=0, period=0, high_cnt=0, state IDLE.
//  Sampling: div_clk through SYNC_STAGES flops -> s; s_d = s delayed 1; rise = s & ~s_d.
//  Counters: on rise, pcnt<=1 and hcnt<=0, else pcnt++ (saturate at 2*DIV+1), hcnt += s.
//   On rise, period<=pcnt and high_cnt<=hcnt (registered, visible the cycle after rise).
//  Good period: pcnt==DIV and floor(DIV/2) <= hcnt <= ceil(DIV/2) (DIV=3: 1..2; even: exactly DIV/2).
//  Timeout: pcnt reaches 2*DIV+1 with no rise (stuck high or low).
//  FSM (one-hot or encoded, registered):
//   IDLE : en=1 -> ACQ. Counters held cleared.
//   ACQ  : first rise -> MEAS (that rise only starts counting; no check), match=0.
//   MEAS : rise&good -> match++; match reaching LOCK_CNT -> LOCKED.
//          rise&bad or timeout -> match=0, stay MEAS; no err pulse (not yet locked).
//   LOCKED: locked=1. rise&bad or timeout -> FAULT, err=1 for one cycle, err_cnt++.
//   FAULT: locked=0; holds until clr_err -> ACQ (err_cnt<=0), or en=0 -> IDLE.
//  en=0 in any state -> IDLE next cycle; locked drops same edge; err_cnt retained.
//  clr_err outside FAULT clears err_cnt only. clr_err coincident with a new fault in LOCKED:
//   fault wins (err pulses, err_cnt becomes 1 from cleared value).
//  locked rises on the clk edge after the LOCK_CNT-th good rise is detected; falls on the
//   edge that registers the fault.
//  Fault detection latency: <= SYNC_STAGES+1 cycles after bad edge, or at timeout.
//  err_cnt saturates at 255; further faults still pulse err.
//  Async reset mid-operation: immediate return to reset values regardless of state.
// TESTING
//  1 DIV=3 ideal div3 (50% duty, negedge-toggling) on div_clk, rstn high @100ps, en=1 ->
//    locked=1 within 5 periods+SYNC_STAGES+2 cycles; period=3, high_cnt in {1,2}; err never.
//  2 After lock, hold div_clk low -> err pulse exactly once 2*DIV+1=7 cycles after last rise;
//    locked=0, err_cnt=1, state FAULT; stays there while stimulus resumes.
//  3 After lock, inject one 4-cycle period -> period=4 reported, err pulse, err_cnt=1;
//    clr_err pulse -> err_cnt=0, relock after LOCK_CNT good periods.
//  4 Before lock, feed alternating 3/4-cycle periods -> never locked, err never pulses.
//  5 Force 260 faults (toggle clr_err-free re-lock via en cycling) -> err_cnt stops at 255.
//  6 Drop rstn while LOCKED -> locked, err, err_cnt, period, high_cnt all 0 immediately;
//    en low mid-MEAS -> IDLE, locked stays 0, err_cnt unchanged.

Source files
------------

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: samples a divided clock, measures period/high time in clk cycles,
// locks after LOCK_CNT good periods and flags/counts faults once locked.
module clk_div_monitor #(
    parameter int DIV         = 3,
    parameter int LOCK_CNT    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CW          = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic          div_clk,
    input  logic          clr_err,
    output logic          locked,
    output logic          err,
    output logic [7:0]    err_cnt,
    output logic [CW-1:0] period,
    output logic [CW-1:0] high_cnt
);
    localparam logic [CW-1:0] TMO  = CW'(2 * DIV + 1);
    localparam logic [CW-1:0] DIVW = CW'(DIV);
    localparam logic [CW-1:0] HLO  = CW'(DIV / 2);
    localparam logic [CW-1:0] HHI  = CW'((DIV + 1) / 2);
    localparam int            MW   = $clog2(LOCK_CNT + 1);

    typedef enum logic [2:0] {IDLE, ACQ, MEAS, LOCKED, FAULT} state_t;

    state_t                 state, nstate;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s, s_d, rise, good, tmo, bad, fault;
    logic [CW-1:0]          pcnt, hcnt;
    logic [MW-1:0]          match, nmatch;
    logic [7:0]             ncnt;

    assign s      = sync[SYNC_STAGES-1];
    assign rise   = s & ~s_d;
    assign good   = pcnt == DIVW && hcnt >= HLO && hcnt <= HHI;
    assign tmo    = ~rise && pcnt == TMO;
    assign bad    = (rise && !good) || tmo;
    assign locked = state == LOCKED;

    always_comb begin
        nstate = state;
        nmatch = match;
        fault  = 1'b0;
        case (state)
            IDLE:   nstate = ACQ;
            ACQ:    if (rise) begin
                        nstate = MEAS;
                        nmatch = '0;
                    end
            MEAS:   if (rise && good) begin
                        nmatch = match + 1'b1;
                        nstate = match == MW'(LOCK_CNT - 1) ? LOCKED : MEAS;
                    end else if (bad) begin
                        nmatch = '0;
                    end
            LOCKED: if (bad) begin
                        fault  = 1'b1;
                        nstate = FAULT;
                    end
            FAULT:  nstate = clr_err ? ACQ : FAULT;
            default: nstate = IDLE;
        endcase
        if (!en) begin
            nstate = IDLE;
            fault  = 1'b0;
        end
        // a fault on the same cycle as clr_err counts from the cleared value
        ncnt = clr_err ? 8'd0 : err_cnt;
        ncnt = (fault && ncnt != 8'hFF) ? ncnt + 1'b1 : ncnt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            sync     <= '0;
            s_d      <= 1'b0;
            match    <= '0;
            err      <= 1'b0;
            err_cnt  <= '0;
            pcnt     <= '0;
            hcnt     <= '0;
            period   <= '0;
            high_cnt <= '0;
        end else begin
            sync    <= SYNC_STAGES'({sync, div_clk});
            s_d     <= s;
            state   <= nstate;
            match   <= nmatch;
            err     <= fault;
            err_cnt <= ncnt;
            if (state == IDLE) begin
                pcnt <= '0;
                hcnt <= '0;
            end else if (rise) begin
                pcnt     <= CW'(1);
                hcnt     <= '0;
                period   <= pcnt;
                high_cnt <= hcnt;
            end else begin
                pcnt <= pcnt == TMO ? TMO : pcnt + 1'b1;
                hcnt <= hcnt + CW'(s);
            end
        end
    end
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: directed and random div_clk stimulus checked every cycle
// against a timestamp-based reference model of the monitor.
`timescale 1ns/1ps
module tb_clk_div_monitor;
    localparam int DIV = 3, LOCK_CNT = 4, SS = 2, CW = 8;
    localparam int TMO = 2 * DIV + 1;

    logic          clk = 0, rstn = 1, en = 0, div_clk = 0, clr_err = 0;
    logic          locked, err;
    logic [7:0]    err_cnt;
    logic [CW-1:0] period, high_cnt;
    int            checks = 0, failures = 0;

    clk_div_monitor #(.DIV(DIV), .LOCK_CNT(LOCK_CNT), .SYNC_STAGES(SS), .CW(CW)) dut (
        .clk(clk), .rstn(rstn), .en(en), .div_clk(div_clk), .clr_err(clr_err),
        .locked(locked), .err(err), .err_cnt(err_cnt), .period(period), .high_cnt(high_cnt)
    );

    always #5 clk = ~clk;

    typedef enum {M_OFF, M_WAIT, M_COUNT, M_LOCK, M_BAD} mode_t;
    mode_t mode;
    bit    hist[$];
    int    edge_n, last_rise, highs, run, e_cnt, e_per, e_hi, gph, n;
    bit    e_err, any_lock, any_err;

    task automatic model_reset();
        mode = M_OFF;
        hist.delete();
        for (int i = 0; i < SS + 2; i++) hist.push_back(1'b0);
        edge_n = 0; last_rise = 1; highs = 0; run = 0;
        e_err = 0; e_cnt = 0; e_per = 0; e_hi = 0;
    endtask

    // one clk edge: period = cycles since last sampled rise, high = sampled highs in between
    task automatic model_step();
        bit cur, prv, rise, tmo, good, bad, flt;
        int since;
        mode_t was;
        hist.push_front(div_clk);
        void'(hist.pop_back());
        edge_n++;
        cur = hist[SS];
        prv = hist[SS+1];
        rise = cur && !prv;
        since = edge_n - last_rise;
        if (since > TMO) since = TMO;
        tmo = !rise && since == TMO;
        good = since == DIV && (highs % 256) >= DIV / 2 && (highs % 256) <= (DIV + 1) / 2;
        bad = (rise && !good) || tmo;
        flt = 0;
        was = mode;
        if (clr_err) e_cnt = 0;
        if (!en) mode = M_OFF;
        else case (mode)
            M_OFF:   mode = M_WAIT;
            M_WAIT:  if (rise) begin mode = M_COUNT; run = 0; end
            M_COUNT: if (rise && good) begin
                         run++;
                         if (run == LOCK_CNT) mode = M_LOCK;
                     end else if (bad) run = 0;
            M_LOCK:  if (bad) begin mode = M_BAD; flt = 1; end
            M_BAD:   if (clr_err) mode = M_WAIT;
        endcase
        if (flt && e_cnt < 255) e_cnt++;
        e_err = flt;
        if (was == M_OFF) begin
            last_rise = edge_n + 1;
            highs = 0;
        end else if (rise) begin
            e_per = since;
            e_hi = highs % 256;
            last_rise = edge_n;
            highs = 0;
        end else highs += cur;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("locked", int'(locked), int'(mode == M_LOCK));
        chk("err", int'(err), int'(e_err));
        chk("err_cnt", int'(err_cnt), e_cnt);
        chk("period", int'(period), e_per);
        chk("high_cnt", int'(high_cnt), e_hi);
    endtask

    task automatic cyc(input bit v);
        div_clk = v;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        any_lock |= locked;
        any_err |= err;
    endtask

    task automatic tick();
        cyc((gph % 3) != 2);
        gph++;
    endtask

    task automatic align();
        while (gph % 3 != 0) tick();
    endtask

    task automatic wait_lock(input int budget, input string tag);
        int k = 0;
        while (!locked && k < budget) begin tick(); k++; end
        chk(tag, int'(locked), 1);
    endtask

    // v: 0/1 = hold div_clk at that level, 2 = keep the ideal divider running
    task automatic wait_err(input int budget, input int v, input string tag, output int k);
        k = 0;
        while (!err && k < budget) begin
            if (v == 2) tick(); else cyc(v == 1);
            k++;
        end
        chk(tag, int'(err), 1);
    endtask

    initial begin
        model_reset();
        gph = 0;
        #1 rstn = 0;
        #1 check_all();
        @(negedge clk);
        rstn = 1;

        // ideal divide-by-3 locks within budget
        en = 1;
        wait_lock(5 * DIV + SS + 2, "t1_lock");
        chk("t1_period", int'(period), 3);
        chk("t1_high_ok", int'(high_cnt inside {8'd1, 8'd2}), 1);
        any_err = 0;
        repeat (30) tick();
        chk("t1_no_err", int'(any_err), 0);

        // stuck low after lock: timeout fault 2*DIV+1 cycles after the last rise
        align();
        wait_err(12, 0, "t2_err", n);
        chk("t2_latency", n, TMO);
        chk("t2_unlocked", int'(locked), 0);
        chk("t2_cnt", int'(err_cnt), 1);
        cyc(0);
        chk("t2_single_pulse", int'(err), 0);
        any_lock = 0;
        repeat (15) tick();
        chk("t2_fault_holds", int'(any_lock), 0);

        // clr_err leaves FAULT, then one 4-cycle period after relock
        clr_err = 1; tick(); clr_err = 0;
        chk("t3_clr", int'(err_cnt), 0);
        wait_lock(30, "t3_lock");
        align();
        cyc(1); cyc(1); cyc(0); cyc(0);
        wait_err(8, 2, "t3_err", n);
        chk("t3_period", int'(period), 4);
        chk("t3_high", int'(high_cnt), 1);
        chk("t3_cnt", int'(err_cnt), 1);
        clr_err = 1; tick(); clr_err = 0;
        chk("t3_clr2", int'(err_cnt), 0);
        wait_lock(LOCK_CNT * DIV + DIV + SS + 6, "t3_relock");

        // clr_err on the same cycle as a new fault: fault counts from zero
        align();
        wait_err(12, 0, "tc_err1", n);
        en = 0; cyc(0); en = 1;
        wait_lock(30, "tc_lock");
        chk("tc_retained", int'(err_cnt), 1);
        align();
        repeat (TMO - 1) cyc(0);
        clr_err = 1; cyc(0); clr_err = 0;
        chk("tc_err", int'(err), 1);
        chk("tc_cnt", int'(err_cnt), 1);

        // alternating 3/4 periods before lock: never locks, never errs
        en = 0; cyc(0); en = 1;
        any_lock = 0; any_err = 0;
        repeat (20) begin
            cyc(1); cyc(1); cyc(0);
            cyc(1); cyc(1); cyc(0); cyc(0);
        end
        chk("t4_never_locked", int'(any_lock), 0);
        chk("t4_never_err", int'(any_err), 0);

        // random periods, duty, clr_err pulses and enable drops
        gph = 0;
        repeat (400) begin
            int len, hi;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 9)) : DIV;
            hi = $urandom_range(1, len - 1);
            if (len == DIV && $urandom_range(0, 1) == 0) hi = DIV - 1;
            for (int j = 0; j < len; j++) begin
                clr_err = ($urandom_range(0, 49) == 0);
                en = ($urandom_range(0, 99) != 0);
                cyc(j < hi);
            end
        end
        clr_err = 0;

        // saturation: 260 faults with enable cycling, no clears
        en = 0; clr_err = 1; cyc(0); clr_err = 0;
        chk("t5_start", int'(err_cnt), 0);
        repeat (260) begin
            en = 1;
            wait_lock(30, "t5_lock");
            align();
            wait_err(12, 0, "t5_err", n);
            en = 0; cyc(0);
        end
        chk("t5_sat", int'(err_cnt), 255);

        // async reset while locked
        en = 1;
        wait_lock(30, "t6_lock");
        rstn = 0;
        #1;
        chk("t6_locked", int'(locked), 0);
        chk("t6_err", int'(err), 0);
        chk("t6_cnt", int'(err_cnt), 0);
        chk("t6_period", int'(period), 0);
        chk("t6_high", int'(high_cnt), 0);
        model_reset();
        @(negedge clk);
        rstn = 1;

        // en low mid-measurement keeps err_cnt and stays unlocked
        wait_lock(30, "t6_relock");
        align();
        wait_err(12, 0, "t6_err1", n);
        en = 0; cyc(0); en = 1;
        repeat (8) tick();
        en = 0; cyc(0);
        chk("t6_idle_unlocked", int'(locked), 0);
        chk("t6_idle_cnt", int'(err_cnt), 1);
        any_lock = 0;
        repeat (20) tick();
        chk("t6_idle_stays", int'(any_lock), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
